// File: rtl/ysyx_24100012_inst_fetch.sv
// ----------------------------------------------------------------------------
// ysyx_24100012_inst_fetch
//
// Instruction fetch unit. Owns the program counter, issues one instruction
// memory read at a time over a valid/ready request channel, buffers the
// returned word in a one-entry output register and hands it, with its PC, to
// the decoder under a valid/ready handshake. A redirect from downstream kills
// any in-flight or buffered fetch and restarts fetching at the target.
//
// Parameters:
//   DATA_WIDTH  width of PC, addresses and instruction word
//   RESET_PC    first fetch address after reset
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   imem_req_valid    out  read request valid
//   imem_req_ready    in   memory accepts the request
//   imem_req_addr     out  read address (current PC)
//   imem_rsp_valid    in   read data valid, one pulse per accepted request
//   imem_rsp_data     in   read data
//   redirect_valid    in   one-cycle redirect pulse
//   redirect_pc       in   redirect target
//   inst_valid        out  instruction/inst_pc valid to the decoder
//   inst_ready        in   decoder consumes the instruction
//   instruction       out  fetched word
//   inst_pc           out  PC of instruction
//   fetch_misalign    out  misaligned-PC flag
//
// Build option:
//   IFU_MISALIGN_TRAP_EN  when defined, a redirect to a target whose low two
//                         bits are non-zero is not fetched; a nop tagged with
//                         that PC and fetch_misalign=1 is presented instead.
//                         When undefined, fetch_misalign is tied to 0 and
//                         redirect targets are used as-is.
// ----------------------------------------------------------------------------
module ysyx_24100012_inst_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  fetch_misalign
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t                r_state,       w_state_n;
    logic [DATA_WIDTH-1:0] r_pc,          w_pc_n;
    logic                  r_kill,        w_kill_n;
    logic                  r_inst_valid,  w_inst_valid_n;
    logic [DATA_WIDTH-1:0] r_instruction, w_instruction_n;
    logic [DATA_WIDTH-1:0] r_inst_pc,     w_inst_pc_n;
    logic [DATA_WIDTH-1:0] w_pc_plus4;

    // Wraps modulo 2^DATA_WIDTH by construction.
    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);

`ifdef IFU_MISALIGN_TRAP_EN
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic r_misalign, w_misalign_n;
    logic w_redirect_misaligned;

    assign w_redirect_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    // Next-state and datapath update. Redirect is checked first in every
    // state because it overrides every other transition.
    always_comb begin
        // NOTE: every variable gets its hold value before the case statement,
        // so no path through the block leaves one unassigned (no latch).
        w_state_n       = r_state;
        w_pc_n          = r_pc;
        w_kill_n        = r_kill;
        w_inst_valid_n  = r_inst_valid;
        w_instruction_n = r_instruction;
        w_inst_pc_n     = r_inst_pc;
`ifdef IFU_MISALIGN_TRAP_EN
        w_misalign_n    = r_misalign;
`endif

        case (r_state)
            IDLE: begin
                w_state_n = REQ;
                if (redirect_valid) begin
                    w_pc_n = redirect_pc;
                end
            end

            REQ: begin
                if (redirect_valid) begin
                    w_pc_n = redirect_pc;
                    if (imem_req_ready) begin
                        // The accepted request is for the old PC: its
                        // response must be thrown away.
                        w_state_n = WAIT;
                        w_kill_n  = 1'b1;
                    end
                end else if (imem_req_ready) begin
                    w_state_n = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    w_pc_n = redirect_pc;
                    if (imem_rsp_valid) begin
                        // Response for the stale PC lands with the redirect:
                        // nothing left outstanding, refetch straight away.
                        w_state_n = REQ;
                        w_kill_n  = 1'b0;
                    end else begin
                        w_kill_n  = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (r_kill) begin
                        w_kill_n  = 1'b0;
                        w_state_n = REQ;
                    end else begin
                        w_instruction_n = imem_rsp_data;
                        w_inst_pc_n     = r_pc;
                        w_inst_valid_n  = 1'b1;
                        w_state_n       = HOLD;
                    end
                end
            end

            HOLD: begin
`ifdef IFU_MISALIGN_TRAP_EN
                // After a misaligned redirect out of WAIT the killed response
                // may still arrive here; retire the kill when it does.
                if (r_kill && imem_rsp_valid) begin
                    w_kill_n = 1'b0;
                end
`endif
                if (redirect_valid) begin
                    // Redirect wins even if the decoder consumes this cycle.
                    w_pc_n         = redirect_pc;
                    w_inst_valid_n = 1'b0;
                    w_state_n      = REQ;
                end else if (inst_ready) begin
                    w_pc_n         = w_pc_plus4;
                    w_inst_valid_n = 1'b0;
                    w_state_n      = REQ;
                end
`ifdef IFU_MISALIGN_TRAP_EN
                if (redirect_valid || inst_ready) begin
                    w_misalign_n = 1'b0;
                end
                // Keep one request outstanding at most: drain the killed
                // response before issuing a new one.
                if (w_state_n == REQ && w_kill_n) begin
                    w_state_n = WAIT;
                end
`endif
            end

            default: begin
                w_state_n = IDLE;
            end
        endcase

`ifdef IFU_MISALIGN_TRAP_EN
        // A misaligned target is never fetched; present a tagged nop instead.
        if (w_redirect_misaligned) begin
            w_pc_n          = redirect_pc;
            w_state_n       = HOLD;
            w_inst_valid_n  = 1'b1;
            w_instruction_n = NOP;
            w_inst_pc_n     = redirect_pc;
            w_misalign_n    = 1'b1;
            if (r_state == REQ) begin
                w_kill_n = imem_req_ready;
            end else if (r_state == WAIT) begin
                w_kill_n = !imem_rsp_valid;
            end
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_kill        <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_instruction <= '0;
            r_inst_pc     <= '0;
        end else begin
            r_state       <= w_state_n;
            r_pc          <= w_pc_n;
            r_kill        <= w_kill_n;
            r_inst_valid  <= w_inst_valid_n;
            r_instruction <= w_instruction_n;
            r_inst_pc     <= w_inst_pc_n;
        end
    end

`ifdef IFU_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_n;
        end
    end

    assign fetch_misalign = r_misalign;
`else
    assign fetch_misalign = 1'b0;
`endif

    assign imem_req_valid = (r_state == REQ);
    assign imem_req_addr  = r_pc;
    assign inst_valid     = r_inst_valid;
    assign instruction    = r_instruction;
    assign inst_pc        = r_inst_pc;

endmodule

// File: tb/tb_ysyx_24100012_inst_fetch.sv
// ----------------------------------------------------------------------------
// Directed testbench for ysyx_24100012_inst_fetch. Inputs change 1 time unit
// after the rising edge; outputs are compared at the same point, well away
// from the next edge. Build with IFU_MISALIGN_TRAP_EN defined to exercise the
// misaligned-redirect trap instead of the pass-through behaviour.
// ----------------------------------------------------------------------------
module tb_ysyx_24100012_inst_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        fetch_misalign;

    int checks = 0;
    int errors = 0;

    ysyx_24100012_inst_fetch #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .fetch_misalign (fetch_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch from REQ with a zero-wait memory and land in HOLD.
    task automatic fetch_word(input logic [31:0] data);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid, fetch_misalign} !== {1'b0, 32'h8000_0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_ctrl: req_valid=%b addr=%h inst_valid=%b misalign=%b, expected 0 80000000 0 0",
                     imem_req_valid, imem_req_addr, inst_valid, fetch_misalign);
        end
        checks++;
        if ({instruction, inst_pc} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: instruction=%h inst_pc=%h, expected 0 0", instruction, inst_pc);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0000}) begin
            errors++;
            $display("FAIL first_req: req_valid=%b addr=%h, expected 1 80000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_zero_wait();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        checks++;
        if ({imem_req_valid, inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL wait_state: req_valid=%b inst_valid=%b, expected 0 0", imem_req_valid, inst_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0010_0093;
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if ({inst_valid, instruction, inst_pc, imem_req_valid} !== {1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("FAIL first_inst: valid=%b inst=%h pc=%h req_valid=%b, expected 1 00100093 80000000 0",
                     inst_valid, instruction, inst_pc, imem_req_valid);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({inst_valid, instruction, inst_pc, imem_req_valid} !== {1'b1, 32'h0010_0093, 32'h8000_0000, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b inst=%h pc=%h req_valid=%b, expected 1 00100093 80000000 0",
                         i, inst_valid, instruction, inst_pc, imem_req_valid);
            end
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h8000_0004, 1'b0}) begin
            errors++;
            $display("FAIL consume_next_req: req_valid=%b addr=%h inst_valid=%b, expected 1 80000004 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
    endtask

    task automatic test_redirect_wait();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        step();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({imem_req_valid, inst_valid} !== 2'b00) begin
                errors++;
                $display("FAIL redir_wait_pending[%0d]: req_valid=%b inst_valid=%b, expected 0 0",
                         i, imem_req_valid, inst_valid);
            end
            step();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0100}) begin
            errors++;
            $display("FAIL redir_wait_drop: inst_valid=%b req_valid=%b addr=%h, expected 0 1 80000100",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_hold();
        fetch_word(32'h0020_0113);
        checks++;
        if ({inst_valid, instruction, inst_pc} !== {1'b1, 32'h0020_0113, 32'h8000_0100}) begin
            errors++;
            $display("FAIL target_inst: valid=%b inst=%h pc=%h, expected 1 00200113 80000100",
                     inst_valid, instruction, inst_pc);
        end
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0040;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0040}) begin
            errors++;
            $display("FAIL redir_hold: inst_valid=%b req_valid=%b addr=%h, expected 0 1 80000040",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        step();
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h8000_0040}) begin
            errors++;
            $display("FAIL redir_hold_steady: req_valid=%b addr=%h, expected 1 80000040", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL redir_req: req_valid=%b addr=%h, expected 1 fffffffc", imem_req_valid, imem_req_addr);
        end
        fetch_word(32'h1234_5678);
        checks++;
        if ({inst_valid, instruction, inst_pc} !== {1'b1, 32'h1234_5678, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL top_inst: valid=%b inst=%h pc=%h, expected 1 12345678 fffffffc",
                     inst_valid, instruction, inst_pc);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0000}) begin
                errors++;
                $display("FAIL wrap_req_stable[%0d]: req_valid=%b addr=%h, expected 1 00000000",
                         i, imem_req_valid, imem_req_addr);
            end
            step();
        end
        fetch_word(32'h0000_0013);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_0004}) begin
            errors++;
            $display("FAIL wrap_next: req_valid=%b addr=%h, expected 1 00000004", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_req_handshake();
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_req_hs_wait: req_valid=%b, expected 0", imem_req_valid);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0200}) begin
            errors++;
            $display("FAIL redir_req_hs_drop: inst_valid=%b req_valid=%b addr=%h, expected 0 1 80000200",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_wait_rsp();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD1_BAD1;
        step();
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        checks++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h8000_0300}) begin
            errors++;
            $display("FAIL redir_wait_rsp: inst_valid=%b req_valid=%b addr=%h, expected 0 1 80000300",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        fetch_word(32'hAABB_CCDD);
        checks++;
        if ({inst_valid, instruction, inst_pc} !== {1'b1, 32'hAABB_CCDD, 32'h8000_0300}) begin
            errors++;
            $display("FAIL after_kill_clear: valid=%b inst=%h pc=%h, expected 1 aabbccdd 80000300",
                     inst_valid, instruction, inst_pc);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if ({inst_valid, instruction, inst_pc} !== {1'b1, 32'hAABB_CCDD, 32'h8000_0300}) begin
            errors++;
            $display("FAIL rsp_in_hold: valid=%b inst=%h pc=%h, expected 1 aabbccdd 80000300",
                     inst_valid, instruction, inst_pc);
        end
    endtask

    task automatic test_reset_mid();
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc} !==
            {1'b0, 32'h8000_0000, 1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid: req_valid=%b addr=%h valid=%b inst=%h pc=%h, expected 0 80000000 0 0 0",
                     imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc);
        end
        step();
        rst = 1'b0;
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_F00D;
        step();
        imem_rsp_valid = 1'b0;
        checks++;
        if ({imem_req_valid, imem_req_addr, inst_valid} !== {1'b1, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("FAIL reset_stale_rsp: req_valid=%b addr=%h valid=%b, expected 1 80000000 0",
                     imem_req_valid, imem_req_addr, inst_valid);
        end
    endtask

`ifdef IFU_MISALIGN_TRAP_EN
    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({imem_req_valid, inst_valid, fetch_misalign, instruction, inst_pc} !==
            {1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h8000_0102}) begin
            errors++;
            $display("FAIL misalign_trap: req_valid=%b valid=%b misalign=%b inst=%h pc=%h, expected 0 1 1 00000013 80000102",
                     imem_req_valid, inst_valid, fetch_misalign, instruction, inst_pc);
        end
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        checks++;
        if ({fetch_misalign, inst_valid} !== 2'b00) begin
            errors++;
            $display("FAIL misalign_clear: misalign=%b valid=%b, expected 0 0", fetch_misalign, inst_valid);
        end
    endtask
`else
    task automatic test_misalign();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        step();
        redirect_valid = 1'b0;
        checks++;
        if ({imem_req_valid, imem_req_addr, fetch_misalign, inst_valid} !== {1'b1, 32'h8000_0102, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL misalign_passthru: req_valid=%b addr=%h misalign=%b valid=%b, expected 1 80000102 0 0",
                     imem_req_valid, imem_req_addr, fetch_misalign, inst_valid);
        end
    endtask
`endif

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        test_reset();
        test_zero_wait();
        test_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_redirect_req_handshake();
        test_redirect_wait_rsp();
        test_reset_mid();
        test_misalign();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
